// File: rtl/univ_shift_reg_p.sv
// univ_shift_reg_p: parametrised universal shift register with a burst engine.
//
// Single-step ops run from IDLE when en=1. A start request with a shift or
// rotate mode latches the mode and amt, then repeats that op amt times while
// busy is high. done pulses for one cycle on the first IDLE cycle after a
// burst, or one cycle after a start with amt=0.
//
// Optional feature macro: USR_PARITY_EN adds output par = ^q, registered with q.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   en      single-step enable (IDLE only)
//   mode    operation select: 000 hold, 001 shl, 010 shr, 011 load,
//           100 rotl, 101 rotr, 110 asr, 111 hold
//   d       parallel load data
//   sin_l   serial in, MSB side
//   sin_r   serial in, LSB side
//   start   burst request (IDLE only)
//   amt     burst repeat count
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   busy    high while a burst is in progress
//   done    one-cycle pulse at burst completion
//   par     (USR_PARITY_EN only) XOR-reduction of q

module univ_shift_reg_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
`ifdef USR_PARITY_EN
    ,
    output logic             par
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic [2:0]       mode_lat_q, mode_lat_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] ld,
                                                  input logic             sl,
                                                  input logic             sr);
        logic [WIDTH-1:0] r;
        r = cur;
        unique case (op)
            3'b001:  r = {cur[WIDTH-2:0], sr};
            3'b010:  r = {sl, cur[WIDTH-1:1]};
            3'b011:  r = ld;
            3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b101:  r = {cur[0], cur[WIDTH-1:1]};
            3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shift/rotate modes can be repeated; hold/load/reserved fall to en.
    logic burst_mode;
    always_comb begin
        burst_mode = 1'b0;
        unique case (mode)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: burst_mode = 1'b1;
            default:                                burst_mode = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_lat_d = mode_lat_q;
        q_d        = q_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && burst_mode) begin
                    // No op on the accepting cycle; the first op lands in RUN.
                    mode_lat_d = mode;
                    if (amt != '0) begin
                        count_d = amt;
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d = apply_op(mode, q_q, d, sin_l, sin_r);
                end
            end
            StRun: begin
                q_d     = apply_op(mode_lat_q, q_q, d, sin_l, sin_r);
                count_d = count_q - 1'b1;
                if (count_q == AW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            mode_lat_q <= '0;
            q_q        <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_lat_q <= mode_lat_d;
            q_q        <= q_d;
            done_q     <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    logic par_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^q_d;
        end
    end
    assign par = par_q;
`endif

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = (state_q == StRun);
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Directed self-checking bench for univ_shift_reg_p (WIDTH=8, AW=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_univ_shift_reg_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;
`ifdef USR_PARITY_EN
    logic       par;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    univ_shift_reg_p #(
        .WIDTH(8),
        .AW   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .amt   (amt),
        .q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
`ifdef USR_PARITY_EN
        ,
        .par   (par)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; amt = 4'd0;

        // 1. Reset and load
        tick(); tick();
        check("reset_q", q, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0; en = 1'b1; mode = 3'b011; d = 8'hA5;
        tick();
        check("load_q", q, 8'hA5);
        check("load_sout_l", sout_l, 1);
        check("load_sout_r", sout_r, 1);
`ifdef USR_PARITY_EN
        check("par_a5", par, 0);
`endif

        // 2. Single shifts
        mode = 3'b001; sin_r = 1'b0; tick();
        check("shl", q, 8'h4A);
        mode = 3'b010; sin_l = 1'b1; tick();
        check("shr", q, 8'hA5);
        mode = 3'b110; tick();
        check("asr", q, 8'hD2);
        mode = 3'b101; tick();
        check("rotr", q, 8'h69);
        en = 1'b0; mode = 3'b001; tick();
        check("en_low_hold", q, 8'h69);
        en = 1'b1; mode = 3'b111; tick();
        check("reserved_hold", q, 8'h69);

        // 3. Burst rotate left x3 from 81, with en/mode noise during RUN
        mode = 3'b011; d = 8'h81; tick();
        check("load_81", q, 8'h81);
        en = 1'b0; mode = 3'b100; amt = 4'd3; start = 1'b1; tick();
        check("burst_start_busy", busy, 1);
        check("burst_start_noop", q, 8'h81);
        start = 1'b0; en = 1'b1; mode = 3'b011; d = 8'hFF; tick();
        check("rotl_1", q, 8'h03);
        check("rotl_1_busy", busy, 1);
        mode = 3'b010; tick();
        check("rotl_2", q, 8'h06);
        tick();
        check("rotl_3", q, 8'h0C);
        check("rotl_busy_low", busy, 0);
        check("rotl_done", done, 1);
        en = 1'b0; mode = 3'b000; tick();
        check("rotl_done_single", done, 0);
        check("rotl_hold", q, 8'h0C);

        // 4a. amt = 0
        mode = 3'b001; amt = 4'd0; start = 1'b1; tick();
        check("amt0_done", done, 1);
        check("amt0_busy", busy, 0);
        check("amt0_q", q, 8'h0C);
        start = 1'b0; tick();
        check("amt0_done_clear", done, 0);

        // 4b. amt = 15, shl with sin_r=1 from 00
        en = 1'b1; mode = 3'b011; d = 8'h00; tick();
        en = 1'b0; mode = 3'b001; sin_r = 1'b1; amt = 4'd15; start = 1'b1; tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            tick();
        end
        check("amt15_busy_cycles", n, 15);
        check("amt15_q", q, 8'hFF);
        check("amt15_done", done, 1);

        // 5. Reset mid-burst: shr x8 with sin_l=0, reset on 4th RUN cycle
        mode = 3'b010; sin_l = 1'b0; amt = 4'd8; start = 1'b1; tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("midburst_q", q, 8'h1F);
        check("midburst_busy", busy, 1);
        rst = 1'b1; tick();
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0; tick();
        check("abort_no_done", done, 0);

        // Subsequent start accepted, then back-to-back start in done cycle
        mode = 3'b001; sin_r = 1'b1; amt = 4'd2; start = 1'b1; tick();
        check("restart_busy", busy, 1);
        start = 1'b0; mode = 3'b000; tick();
        check("restart_op1", q, 8'h01);
        tick();
        check("restart_op2", q, 8'h03);
        check("restart_done", done, 1);
        mode = 3'b100; amt = 4'd1; start = 1'b1; tick();
        check("b2b_busy", busy, 1);
        check("b2b_noop", q, 8'h03);
        start = 1'b0; tick();
        check("b2b_q", q, 8'h06);
        check("b2b_done", done, 1);

        // 6. Load 07 (parity 1 when enabled)
        en = 1'b1; mode = 3'b011; d = 8'h07; tick();
        check("load_07", q, 8'h07);
`ifdef USR_PARITY_EN
        check("par_07", par, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
